dmac_read_split: RTL and testbench
==================================

Name: dmac_read_split

Overview:
- Parametrised read engine for the DMA controller: accepts one transfer descriptor (source address, beat count) and fetches the data over AXI.
- Splits the transfer into INCR bursts that never exceed MAX_BEATS and never cross a 4 KB boundary.
- Buffers read data in an internal FIFO, so the write side can apply backpressure.
- Reports completion and error status per transfer.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width in bits; power of two, at least 8; beat size is DATA_W/8 bytes
ID_W, 4, AXI ID width
AR_ID, 1, constant ARID value
MAX_BEATS, 16, maximum beats per burst; 1..256
FIFO_DEPTH, 16, read-data FIFO entries; power of two, at least MAX_BEATS
CNT_W, 16, width of the transfer beat count

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  descriptor valid; sampled only in IDLE
src_addr_i  in  ADDR_W  start address; low log2(DATA_W/8) bits ignored (treated as 0)
total_beats_i  in  CNT_W  beats to transfer; 0 is legal
busy_o  out  1  high from the cycle after start acceptance until done_o
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky error flag; valid with done_o, cleared on next start
data_o  out  DATA_W  FIFO head data
data_valid_o  out  1  FIFO not empty
data_ready_i  in  1  consumer pops when data_valid_o and data_ready_i are both high
m_arid  out  ID_W  equals AR_ID
m_araddr  out  ADDR_W  burst address
m_arlen  out  8  burst beats minus 1
m_arsize  out  3  log2(DATA_W/8)
m_arburst  out  2  2'b01 (INCR)
m_arvalid  out  1  AR valid
m_arready  in  1  AR ready
m_rid  in  ID_W  ignored
m_rdata  in  DATA_W  read data
m_rresp  in  2  read response
m_rvalid  in  1  R valid
m_rlast  in  1  last beat of burst
m_rready  out  1  R ready

Behaviour:
- Reset values:
  - All outputs 0 except the constants m_arid, m_arsize, m_arburst.
  - State IDLE; FIFO emptied; counters and err cleared.
- States and transitions:
  - IDLE: on start_i, latch aligned address and remaining count, clear err.
    - Count 0: go to FIN.
    - Otherwise: go to CALC.
  - CALC (1 cycle):
    - to_4k = (4096 - addr[11:0]) >> log2(DATA_W/8).
    - len = min(remaining, MAX_BEATS, to_4k).
    - Register m_araddr and m_arlen = len-1. Go to AR.
  - AR:
    - m_arvalid = 1 only when FIFO free entries >= len; this is the space credit.
    - Once asserted, m_arvalid, m_araddr and m_arlen hold until m_arready.
    - On handshake: addr += len*DATA_W/8, remaining -= len, beat counter = len. Go to R.
  - R:
    - m_rready = 1 throughout; space is guaranteed by the credit.
    - Every R handshake pushes m_rdata into the FIFO and decrements the beat counter.
    - m_rresp[1] = 1 on any beat sets err. Data is still pushed and the transfer continues.
    - On a beat with m_rlast: go to CALC if remaining != 0, else go to FIN.
    - m_rlast on a beat other than the counted last beat, or no m_rlast on the counted last beat: set err. Burst end is always taken from m_rlast.
  - FIN: done_o = 1 for one cycle, busy_o drops with it. Go to IDLE. FIN does not wait for the FIFO to drain.
- Concurrency:
  - At most one outstanding AR per engine.
  - start_i outside IDLE is ignored.
- FIFO:
  - Push and pop may occur in the same cycle, including when full or empty with a simultaneous push.
  - Count width is log2(FIFO_DEPTH)+1.
  - data_o is valid in the same cycle data_valid_o is high (registered storage, show-ahead).
  - Latency from R handshake to data_valid_o is 1 cycle.
- Arithmetic:
  - Address adds wrap modulo 2^ADDR_W.
  - remaining never underflows, since len <= remaining.
- Reset mid-transfer: immediate return to IDLE, FIFO flushed, outputs at reset values. Any in-flight AXI transaction is the system's responsibility; the whole fabric is reset together.

Test Plan:
- Basic transfer: DATA_W=32, src 0x1000, 4 beats, consumer always ready -> one AR with araddr 0x1000 and arlen 3. Data 0xA0..0xA3 appear on data_o in order. done_o pulses once, err_o=0.
- MAX_BEATS split: src 0x2000, 40 beats -> three ARs: 0x2000/arlen 15, 0x2040/arlen 15, 0x2080/arlen 7. 40 pops total, done_o once.
- 4 KB crossing: src 0x0FF8, 8 beats -> AR 0x0FF8/arlen 1, then AR 0x1000/arlen 5. Neither burst spans 0x1000.
- Backpressure: data_ready_i=0, 32 beats, FIFO_DEPTH 16 -> first burst fills the FIFO and the second AR is withheld, m_arvalid=0. Raising data_ready_i drains the FIFO, the second AR issues, and no data is lost or reordered.
- Errors and corner cases:
  - SLVERR (rresp=2'b10) on beat 2 of 4 -> all 4 beats delivered, err_o=1 at done_o.
  - Next start -> err_o cleared.
  - total_beats_i=0 -> done_o two cycles after start with no AR.
- Reset: rst_i asserted mid-R with the FIFO holding 3 entries -> data_valid_o=0, busy_o=0, m_arvalid=0 immediately (asynchronous). A new start after reset completes normally.

Source files
------------

// File: rtl/dmac_read_split_if.sv
// dmac_read_split_if: AXI read address and read data channels of the DMA read engine.
// Ports (signals): m_arid/m_araddr/m_arlen/m_arsize/m_arburst/m_arvalid/m_arready form the AR channel;
// m_rid/m_rdata/m_rresp/m_rvalid/m_rlast/m_rready form the R channel.
// The master modport belongs to the engine and the slave modport to the memory side.
interface dmac_read_split_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   m_arid;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_arvalid;
  logic              m_arready;
  logic [ID_W-1:0]   m_rid;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rlast;
  logic              m_rready;
  modport master (
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_arready, m_rid, m_rdata, m_rresp, m_rvalid, m_rlast
  );
  modport slave (
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_arready, m_rid, m_rdata, m_rresp, m_rvalid, m_rlast
  );
endinterface

// File: rtl/dmac_read_split.sv
// dmac_read_split: DMA read engine that fetches one descriptor as INCR bursts into a show-ahead FIFO.
// Ports: clk_i/rst_i clock and async active-high reset; start_i/src_addr_i/total_beats_i descriptor;
// busy_o/done_o/err_o status; data_o/data_valid_o/data_ready_i FIFO read side; m AXI read master.
// Bursts are capped at MAX_BEATS and never cross a 4 KB boundary.
module dmac_read_split #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int AR_ID      = 1,
  parameter int MAX_BEATS  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   src_addr_i,
  input  logic [CNT_W-1:0]    total_beats_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [DATA_W-1:0]   data_o,
  output logic                data_valid_o,
  input  logic                data_ready_i,
  dmac_read_split_if.master   m
);
  localparam int SZ = $clog2(DATA_W / 8);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W  = CNT_W > 13 ? CNT_W : 13;
  typedef enum logic [2:0] {IDLE, CALC, AR, R, FIN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [8:0]        len, beats, len_c;
  logic [12:0]       to_4k, cap;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push, pop;
  assign m.m_arid    = ID_W'(AR_ID);
  assign m.m_arsize  = 3'(SZ);
  assign m.m_arburst = 2'b01;
  assign pop          = data_valid_o && data_ready_i;
  // The AR credit guarantees room; the guard only keeps a misbehaving slave from overwriting the head.
  assign push         = m.m_rvalid && m.m_rready && (count != (AW+1)'(FIFO_DEPTH) || pop);
  assign data_valid_o = count != '0;
  assign data_o       = data_valid_o ? mem[rd_ptr] : '0;
  assign to_4k = (13'h1000 - {1'b0, addr[11:0]}) >> SZ;
  assign cap   = to_4k < 13'(MAX_BEATS) ? to_4k : 13'(MAX_BEATS);
  assign len_c = W'(remaining) < W'(cap) ? 9'(remaining) : 9'(cap);
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= m.m_rdata;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      len         <= '0;
      beats       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      m.m_araddr  <= '0;
      m.m_arlen   <= '0;
      m.m_arvalid <= 1'b0;
      m.m_rready  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          addr      <= src_addr_i & ~ADDR_W'(DATA_W / 8 - 1);
          remaining <= total_beats_i;
          err_o     <= 1'b0;
          busy_o    <= 1'b1;
          state     <= total_beats_i == '0 ? FIN : CALC;
        end
        CALC: begin
          len        <= len_c;
          m.m_araddr <= addr;
          m.m_arlen  <= 8'(len_c - 9'd1);
          state      <= AR;
        end
        // Free space only grows while waiting here, so a raised valid can safely hold.
        AR: if (!m.m_arvalid) m.m_arvalid <= 32'(FIFO_DEPTH) - 32'(count) >= 32'(len);
        else if (m.m_arready) begin
          m.m_arvalid <= 1'b0;
          m.m_rready  <= 1'b1;
          addr        <= addr + (ADDR_W'(len) << SZ);
          remaining   <= remaining - CNT_W'(len);
          beats       <= len;
          state       <= R;
        end
        R: if (m.m_rvalid) begin
          beats <= beats - 9'd1;
          if (m.m_rresp[1] || m.m_rlast != (beats == 9'd1)) err_o <= 1'b1;
          if (m.m_rlast) begin
            m.m_rready <= 1'b0;
            state      <= remaining != '0 ? CALC : FIN;
          end
        end
        FIN: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmac_read_split.sv
// tb_dmac_read_split: directed bench for dmac_read_split with a queue-based AXI read slave and a checking consumer.
module tb_dmac_read_split;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] src_addr_i;
  logic [15:0] total_beats_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i;
  int n_chk = 0, n_bad = 0;
  int rbase, err_at, stall_n, bad_last;
  int nbeat, npop, ndone, bt;
  logic err_done;
  int pend[$];
  int ar_addr[$], ar_len[$];
  logic ar_hs, r_hs;
  int snap_a, snap_l;
  dmac_read_split_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();
  dmac_read_split dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .src_addr_i(src_addr_i),
    .total_beats_i(total_beats_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .m(axi)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Slave and consumer run 1 time unit after each falling edge: first the handshakes of the
  // rising edge just passed are retired, then new drives are set and the next handshakes noted.
  initial begin
    axi.m_arready = 1'b0; axi.m_rvalid = 1'b0; axi.m_rlast = 1'b0;
    axi.m_rdata = '0; axi.m_rresp = 2'b00; axi.m_rid = '0;
    ar_hs = 1'b0; r_hs = 1'b0; bt = 0;
    forever begin
      @(negedge clk_i); #1;
      if (rst_i) begin
        pend.delete(); bt = 0; ar_hs = 1'b0; r_hs = 1'b0;
        axi.m_arready = 1'b0; axi.m_rvalid = 1'b0; axi.m_rlast = 1'b0;
        continue;
      end
      if (ar_hs) begin
        pend.push_back(snap_l); ar_addr.push_back(snap_a); ar_len.push_back(snap_l);
      end
      if (r_hs) begin
        nbeat++;
        if (axi.m_rlast) begin void'(pend.pop_front()); bt = 0; end
        else bt++;
      end
      axi.m_arready = 1'b1;
      if (pend.size() != 0 && (stall_n < 0 || nbeat < stall_n)) begin
        axi.m_rvalid = 1'b1;
        axi.m_rdata  = 32'(rbase + nbeat);
        axi.m_rresp  = nbeat == err_at ? 2'b10 : 2'b00;
        axi.m_rlast  = bt == pend[0] - bad_last;
      end else begin
        axi.m_rvalid = 1'b0; axi.m_rlast = 1'b0; axi.m_rresp = 2'b00;
      end
      ar_hs  = axi.m_arvalid && axi.m_arready;
      snap_a = int'(axi.m_araddr);
      snap_l = int'(axi.m_arlen);
      r_hs   = axi.m_rvalid && axi.m_rready;
      if (data_valid_o && data_ready_i) begin
        chk("pop data", data_o, 64'(rbase + npop));
        npop++;
      end
      if (done_o) begin ndone++; err_done = err_o; end
    end
  end
  task automatic setup(input int base);
    rbase = base; nbeat = 0; npop = 0; ndone = 0; err_done = 1'bx;
    err_at = -1; stall_n = -1; bad_last = 0;
    ar_addr.delete(); ar_len.delete();
  endtask
  task automatic go(input logic [31:0] a, input logic [15:0] n);
    @(negedge clk_i);
    src_addr_i = a; total_beats_i = n; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask
  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (done_o) break;
    end
    chk("done within budget", i < budget, 1);
    repeat (4) @(negedge clk_i);
  endtask
  task automatic chk_ar(input string tag, input int idx, input int a, input int l);
    chk({tag, " araddr"}, 64'(ar_addr[idx]), 64'(a));
    chk({tag, " arlen"}, 64'(ar_len[idx]), 64'(l));
  endtask
  task automatic chk_end(input string tag, input int nar, input int pops, input logic e);
    chk({tag, " ar count"}, 64'(ar_addr.size()), 64'(nar));
    chk({tag, " pops"}, 64'(npop), 64'(pops));
    chk({tag, " done count"}, 64'(ndone), 1);
    chk({tag, " err at done"}, err_done, e);
    chk({tag, " busy after"}, busy_o, 0);
  endtask
  initial begin
    rst_i = 1'b1; start_i = 1'b0; src_addr_i = '0; total_beats_i = '0; data_ready_i = 1'b0;
    setup(0);
    repeat (2) @(negedge clk_i);
    chk("reset status", {busy_o, done_o, err_o, data_valid_o}, 0);
    chk("reset data_o", data_o, 0);
    chk("reset ar/r", {axi.m_arvalid, axi.m_rready, axi.m_araddr, axi.m_arlen}, 0);
    chk("reset arid", axi.m_arid, 1);
    chk("reset arsize", axi.m_arsize, 2);
    chk("reset arburst", axi.m_arburst, 1);
    rst_i = 1'b0;
    data_ready_i = 1'b1;
    setup(32'hA0); go(32'h1000, 4);
    chk("basic busy", busy_o, 1);
    wait_done(100);
    chk_ar("basic", 0, 32'h1000, 3);
    chk_end("basic", 1, 4, 1'b0);
    setup(32'h100); go(32'h2000, 40); wait_done(300);
    chk_ar("split0", 0, 32'h2000, 15);
    chk_ar("split1", 1, 32'h2040, 15);
    chk_ar("split2", 2, 32'h2080, 7);
    chk_end("split", 3, 40, 1'b0);
    setup(32'h200); go(32'h0FF8, 8); wait_done(100);
    chk_ar("4k0", 0, 32'h0FF8, 1);
    chk_ar("4k1", 1, 32'h1000, 5);
    chk_end("4k", 2, 8, 1'b0);
    setup(32'h300); go(32'h0123, 1); wait_done(100);
    chk_ar("align", 0, 32'h0120, 0);
    chk_end("align", 1, 1, 1'b0);
    setup(32'h400); data_ready_i = 1'b0; go(32'h3000, 32);
    repeat (40) @(negedge clk_i);
    chk("bp ar count", 64'(ar_addr.size()), 1);
    chk("bp beats", 64'(nbeat), 16);
    chk("bp arvalid held", axi.m_arvalid, 0);
    chk("bp valid/busy", {data_valid_o, busy_o}, 2'b11);
    data_ready_i = 1'b1;
    wait_done(200);
    chk_ar("bp0", 0, 32'h3000, 15);
    chk_ar("bp1", 1, 32'h3040, 15);
    chk_end("bp", 2, 32, 1'b0);
    setup(32'h500); err_at = 1; go(32'h4000, 4); wait_done(100);
    chk_end("slverr", 1, 4, 1'b1);
    chk("err sticky", err_o, 1);
    setup(32'h600); go(32'h4100, 1);
    chk("err cleared", err_o, 0);
    wait_done(100);
    chk_end("clear", 1, 1, 1'b0);
    setup(32'h700); bad_last = 1; go(32'h4200, 4); wait_done(100);
    chk_end("early last", 1, 3, 1'b1);
    setup(32'h800); go(32'h5000, 0);
    chk("zero c1 done/busy", {done_o, busy_o}, 2'b01);
    @(negedge clk_i);
    chk("zero c2 done/busy", {done_o, busy_o}, 2'b10);
    @(negedge clk_i);
    chk("zero c3 done", done_o, 0);
    repeat (3) @(negedge clk_i);
    chk("zero ar count", 64'(ar_addr.size()), 0);
    setup(32'h900); data_ready_i = 1'b0; stall_n = 3; go(32'h6000, 8);
    for (int i = 0; i < 50 && nbeat < 3; i++) @(negedge clk_i);
    repeat (2) @(negedge clk_i);
    chk("pre-reset beats", 64'(nbeat), 3);
    chk("pre-reset valid/busy", {data_valid_o, busy_o}, 2'b11);
    #2 rst_i = 1'b1;
    #1;
    chk("async reset valid/busy", {data_valid_o, busy_o}, 0);
    chk("async reset ar/r", {axi.m_arvalid, axi.m_rready}, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    data_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    setup(32'hA00); go(32'h7000, 5); wait_done(100);
    chk_ar("post-reset", 0, 32'h7000, 4);
    chk_end("post-reset", 1, 5, 1'b0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
